// File: rtl/tof_pkg.sv
// tof_pkg: shared types and constants for the time-of-flight capture block.
//   tof_state_e   - measurement FSM states
//   TOF_*_DEF     - default values for the tof_capture parameters
//   TOF_NONE      - tof value reported for a channel that never tripped
//   tick_sat_inc  - saturating 32-bit increment used by the tick counter
package tof_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_LISTEN = 2'd2,
    ST_DONE   = 2'd3
  } tof_state_e;

  localparam int unsigned TOF_HALF_PERIOD_DEF   = 32'd1250;
  localparam int unsigned TOF_BURST_HALVES_DEF  = 32'd6;
  localparam int unsigned TOF_BLANK_TICKS_DEF   = 32'd10000;
  localparam int unsigned TOF_TIMEOUT_TICKS_DEF = 32'd2000000;
  localparam int unsigned TOF_FILTER_CYCLES_DEF = 32'd4;

  localparam logic [31:0] TOF_NONE = 32'hFFFF_FFFF;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] tick_sat_inc(input logic [31:0] v);
    logic [31:0] r;
    if (v == TOF_NONE) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tof_sync_edge.sv
// tof_sync_edge: brings one asynchronous comparator trip into the clk domain
// and flags its rising edge.
//   clk   - system clock
//   reset - asynchronous active-low reset, clears every flop
//   trip  - asynchronous comparator output
//   rise  - high for one cycle when the (optionally filtered) trip goes high
// Build option: TOF_GLITCH_FILTER_EN inserts a consecutive-high filter of
// FILTER_CYCLES samples between the synchronizer and the edge detector.
module tof_sync_edge
  import tof_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = TOF_FILTER_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic trip,
  output logic rise
);

  logic meta_r;
  logic sync_r;
  logic level_s;
  logic prev_r;

  // Two-flop synchronizer for the asynchronous trip input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= trip;
      sync_r <= meta_r;
    end
  end

`ifdef TOF_GLITCH_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(FILTER_CYCLES - 1);

  // run_r counts earlier consecutive high samples, so the current sample
  // completes the run when run_r has reached FILTER_CYCLES-1.
  logic [CNT_W-1:0] run_r;

  // Consecutive-high run counter, saturating at the threshold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_r <= '0;
    end else if (!sync_r) begin
      run_r <= '0;
    end else if (run_r != THRESH_C) begin
      run_r <= run_r + CNT_W'(1);
    end else begin
      run_r <= run_r;
    end
  end

  assign level_s = sync_r && (run_r == THRESH_C);
`else
  assign level_s = sync_r;
`endif

  // Previous level for the rise detector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= level_s;
    end
  end

  assign rise = level_s && !prev_r;

endmodule

// File: rtl/tof_capture.sv
// tof_capture: ultrasonic time-of-flight measurement. A start request fires a
// transmit burst, then the tick count at the first trip of each receiver is
// captured. Trips inside the blanking window are ignored; a measurement that
// runs to TIMEOUT_TICKS-1 ends with timeout set and missing channels at
// all-ones. Synchronizer latency (two cycles) is included in the results.
//   clk, reset        - system clock, asynchronous active-low reset
//   start             - request one measurement (honoured only when idle)
//   tripone, triptwo  - asynchronous receiver comparator outputs
//   tx_out            - transmit burst
//   busy              - measurement in progress (any state but IDLE)
//   complete          - one-cycle pulse when tof_one/tof_two/timeout are valid
//   tof_one, tof_two  - captured tick counts
//   timeout           - last measurement timed out
// Build option: TOF_GLITCH_FILTER_EN enables the trip glitch filter.
module tof_capture
  import tof_pkg::*;
#(
  parameter int unsigned HALF_PERIOD   = TOF_HALF_PERIOD_DEF,
  parameter int unsigned BURST_HALVES  = TOF_BURST_HALVES_DEF,
  parameter int unsigned BLANK_TICKS   = TOF_BLANK_TICKS_DEF,
  parameter int unsigned TIMEOUT_TICKS = TOF_TIMEOUT_TICKS_DEF,
  parameter int unsigned FILTER_CYCLES = TOF_FILTER_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        tripone,
  input  logic        triptwo,
  output logic        tx_out,
  output logic        busy,
  output logic        complete,
  output logic [31:0] tof_one,
  output logic [31:0] tof_two,
  output logic        timeout
);

  localparam logic [31:0] HALF_END_C    = 32'(HALF_PERIOD - 1);
  localparam logic [31:0] BURST_END_C   = 32'(BURST_HALVES * HALF_PERIOD - 1);
  localparam logic [31:0] BLANK_C       = 32'(BLANK_TICKS);
  localparam logic [31:0] TIMEOUT_END_C = 32'(TIMEOUT_TICKS - 1);

  tof_state_e  state_r;
  tof_state_e  state_nxt_s;
  logic [31:0] tick_r;
  logic [31:0] half_cnt_r;
  logic        cap_one_r;
  logic        cap_two_r;
  logic        tx_r;
  logic        busy_r;
  logic        complete_r;
  logic        timeout_r;
  logic [31:0] tof_one_r;
  logic [31:0] tof_two_r;

  logic rise_one_s;
  logic rise_two_s;
  logic armed_s;
  logic lat_one_s;
  logic lat_two_s;
  logic cap_one_nxt_s;
  logic cap_two_nxt_s;
  logic timeout_hit_s;

  tof_sync_edge #(.FILTER_CYCLES(FILTER_CYCLES)) u_sync_one (
    .clk   (clk),
    .reset (reset),
    .trip  (tripone),
    .rise  (rise_one_s)
  );

  tof_sync_edge #(.FILTER_CYCLES(FILTER_CYCLES)) u_sync_two (
    .clk   (clk),
    .reset (reset),
    .trip  (triptwo),
    .rise  (rise_two_s)
  );

  // Capture qualification; both channels may latch in the same cycle.
  assign armed_s       = ((state_r == ST_BURST) || (state_r == ST_LISTEN)) && (tick_r >= BLANK_C);
  assign lat_one_s     = armed_s && rise_one_s && !cap_one_r;
  assign lat_two_s     = armed_s && rise_two_s && !cap_two_r;
  assign cap_one_nxt_s = cap_one_r || lat_one_s;
  assign cap_two_nxt_s = cap_two_r || lat_two_s;

  // Next-state logic; a latch in the final listen cycle beats the timeout.
  always_comb begin
    state_nxt_s   = state_r;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_BURST;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (tick_r == BURST_END_C) begin
          state_nxt_s = ST_LISTEN;
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
      ST_LISTEN: begin
        if (cap_one_nxt_s && cap_two_nxt_s) begin
          state_nxt_s = ST_DONE;
        end else if (tick_r == TIMEOUT_END_C) begin
          state_nxt_s   = ST_DONE;
          timeout_hit_s = 1'b1;
        end else begin
          state_nxt_s = ST_LISTEN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      complete_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
      complete_r <= (state_nxt_s == ST_DONE);
    end
  end

  // Measurement datapath: tick, burst generator, capture and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_r     <= 32'd0;
      half_cnt_r <= 32'd0;
      cap_one_r  <= 1'b0;
      cap_two_r  <= 1'b0;
      tx_r       <= 1'b0;
      timeout_r  <= 1'b0;
      tof_one_r  <= 32'd0;
      tof_two_r  <= 32'd0;
    end else if (state_r == ST_IDLE) begin
      if (start) begin
        tick_r     <= 32'd0;
        half_cnt_r <= 32'd0;
        cap_one_r  <= 1'b0;
        cap_two_r  <= 1'b0;
        tx_r       <= 1'b1;
        timeout_r  <= 1'b0;
        tof_one_r  <= 32'd0;
        tof_two_r  <= 32'd0;
      end
    end else begin
      cap_one_r <= cap_one_nxt_s;
      cap_two_r <= cap_two_nxt_s;
      // tick freezes on the way into DONE so it still shows the final count.
      if ((state_nxt_s == ST_BURST) || (state_nxt_s == ST_LISTEN)) begin
        tick_r <= tick_sat_inc(tick_r);
      end
      if (state_r == ST_BURST) begin
        if (state_nxt_s == ST_LISTEN) begin
          tx_r       <= 1'b0;
          half_cnt_r <= 32'd0;
        end else if (half_cnt_r == HALF_END_C) begin
          tx_r       <= !tx_r;
          half_cnt_r <= 32'd0;
        end else begin
          half_cnt_r <= half_cnt_r + 32'd1;
        end
      end
      if (lat_one_s) begin
        tof_one_r <= tick_r;
      end else if (timeout_hit_s && !cap_one_nxt_s) begin
        tof_one_r <= TOF_NONE;
      end
      if (lat_two_s) begin
        tof_two_r <= tick_r;
      end else if (timeout_hit_s && !cap_two_nxt_s) begin
        tof_two_r <= TOF_NONE;
      end
      if (timeout_hit_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign tx_out   = tx_r;
  assign busy     = busy_r;
  assign complete = complete_r;
  assign timeout  = timeout_r;
  assign tof_one  = tof_one_r;
  assign tof_two  = tof_two_r;

endmodule
